// File: rtl/traffic_phase_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | traffic_pkg: light encodings, phase codes and approach indices   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package traffic_pkg;

    typedef logic [1:0] light_t;
    typedef logic [1:0] dir_t;
    typedef logic [2:0] phase_t;

    localparam light_t LIGHT_RED    = 2'b00;
    localparam light_t LIGHT_YELLOW = 2'b01;
    localparam light_t LIGHT_GREEN  = 2'b10;

    localparam phase_t ST_IDLE          = 3'd0;
    localparam phase_t ST_GREEN         = 3'd1;
    localparam phase_t ST_YELLOW        = 3'd2;
    localparam phase_t ST_ALL_RED       = 3'd3;
    localparam phase_t ST_PREEMPT_GREEN = 3'd4;

    localparam dir_t DIR_NS = 2'd0;
    localparam dir_t DIR_SN = 2'd1;
    localparam dir_t DIR_EW = 2'd2;
    localparam dir_t DIR_WE = 2'd3;

    // Only the served approach may show anything other than red.
    function automatic light_t light_decode(input phase_t st, input dir_t act, input dir_t ap);
        light_t res;
        res = LIGHT_RED;
        if (ap == act) begin
            case (st)
                ST_GREEN, ST_PREEMPT_GREEN: res = LIGHT_GREEN;
                ST_YELLOW:                  res = LIGHT_YELLOW;
                default:                    res = LIGHT_RED;
            endcase
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | traffic_phase_arbiter_if: sensor inputs and light outputs        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface traffic_phase_arbiter_if;
    import traffic_pkg::*;

    logic [3:0] req;
    logic [3:0] ext;
    logic       preempt;
    dir_t       preempt_dir;
    light_t     NS_light;
    light_t     SN_light;
    light_t     EW_light;
    light_t     WE_light;
    dir_t       active_dir;
    phase_t     phase_state;
    logic       preempt_ack;

    modport master (
        output req, ext, preempt, preempt_dir,
        input  NS_light, SN_light, EW_light, WE_light,
        input  active_dir, phase_state, preempt_ack
    );

    modport slave (
        input  req, ext, preempt, preempt_dir,
        output NS_light, SN_light, EW_light, WE_light,
        output active_dir, phase_state, preempt_ack
    );

endinterface
`default_nettype wire

// File: rtl/traffic_phase_arbiter_rr_select.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_select: 4-way round-robin picker starting after last_dir      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_select
    import traffic_pkg::*;
(
    input  wire logic [3:0] eff_i,
    input  wire dir_t       last_dir_i,
    output dir_t            sel_dir_o,
    output logic            any_o
);

    dir_t w_cand;
    logic w_found;

    always_comb begin
        sel_dir_o = last_dir_i + 2'd1;
        w_cand    = last_dir_i;
        w_found   = 1'b0;
        // Offset 4 wraps back onto last_dir itself, so it has lowest priority.
        for (int i = 1; i <= 4; i++) begin
            w_cand = last_dir_i + 2'(i);
            if (!w_found && eff_i[w_cand]) begin
                sel_dir_o = w_cand;
                w_found   = 1'b1;
            end
        end
        any_o = |eff_i;
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | traffic_phase_arbiter: round-robin green scheduler with preempt  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 2,
    parameter int TW        = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    traffic_phase_arbiter_if.slave  bus
);

    localparam logic [TW-1:0] c_MIN_GREEN = TW'(MIN_GREEN);
    localparam logic [TW-1:0] c_MAX_GREEN = TW'(MAX_GREEN);
    localparam logic [TW-1:0] c_YELLOW_T  = TW'(YELLOW_T);
    localparam logic [TW-1:0] c_ALL_RED_T = TW'(ALL_RED_T);
    localparam logic [TW-1:0] c_ONE       = TW'(1);

    phase_t        state_q,   state_d;
    dir_t          active_q,  active_d;
    dir_t          last_q,    last_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic [3:0]    pending_q, pending_d;
    logic          pre_lat_q, pre_lat_d;
    dir_t          pre_dir_q, pre_dir_d;

    light_t        ns_q, ns_d;
    light_t        sn_q, sn_d;
    light_t        ew_q, ew_d;
    light_t        we_q, we_d;
    logic          ack_q, ack_d;

    logic [3:0]    w_eff;
    dir_t          w_pdir;
    dir_t          w_sel;
    logic          w_any;
    logic [TW-1:0] w_timer_inc;
    logic          w_other;
    logic          w_grant;
    dir_t          w_gdir;

    assign w_eff       = pending_q | bus.req;
    assign w_pdir      = pre_lat_q ? pre_dir_q : bus.preempt_dir;
    assign w_timer_inc = (timer_q >= c_MAX_GREEN) ? timer_q : timer_q + c_ONE;
    assign w_other     = |(w_eff & ~(4'b0001 << active_q));

    rr_select u_rr_select (
        .eff_i      (w_eff),
        .last_dir_i (last_q),
        .sel_dir_o  (w_sel),
        .any_o      (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            active_q  <= DIR_NS;
            last_q    <= DIR_WE;
            timer_q   <= '0;
            pending_q <= '0;
            pre_lat_q <= 1'b0;
            pre_dir_q <= DIR_NS;
            ns_q      <= LIGHT_RED;
            sn_q      <= LIGHT_RED;
            ew_q      <= LIGHT_RED;
            we_q      <= LIGHT_RED;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            pre_lat_q <= pre_lat_d;
            pre_dir_q <= pre_dir_d;
            ns_q      <= ns_d;
            sn_q      <= sn_d;
            ew_q      <= ew_d;
            we_q      <= we_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        last_d    = last_q;
        timer_d   = timer_q;
        pre_lat_d = bus.preempt;
        pre_dir_d = (bus.preempt && !pre_lat_q) ? bus.preempt_dir : pre_dir_q;
        pending_d = pending_q | bus.req;
        w_grant   = 1'b0;
        w_gdir    = active_q;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (bus.preempt) begin
                    state_d = ST_PREEMPT_GREEN;
                    w_grant = 1'b1;
                    w_gdir  = w_pdir;
                end else if (w_any) begin
                    state_d = ST_GREEN;
                    w_grant = 1'b1;
                    w_gdir  = w_sel;
                end
            end
            ST_GREEN: begin
                // A preempt for the approach already green skips clearance entirely.
                if (bus.preempt && (w_pdir == active_q)) begin
                    state_d = ST_PREEMPT_GREEN;
                    w_grant = 1'b1;
                    w_gdir  = active_q;
                end else if (bus.preempt
                             || ((timer_q >= c_MIN_GREEN) && !bus.ext[active_q])
                             || ((timer_q == c_MAX_GREEN) && w_other)) begin
                    state_d = ST_YELLOW;
                    timer_d = c_ONE;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            ST_YELLOW: begin
                if (timer_q >= c_YELLOW_T) begin
                    state_d = ST_ALL_RED;
                    timer_d = c_ONE;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            ST_ALL_RED: begin
                if (timer_q >= c_ALL_RED_T) begin
                    if (bus.preempt) begin
                        state_d = ST_PREEMPT_GREEN;
                        w_grant = 1'b1;
                        w_gdir  = w_pdir;
                    end else if (w_any) begin
                        state_d = ST_GREEN;
                        w_grant = 1'b1;
                        w_gdir  = w_sel;
                    end else begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            ST_PREEMPT_GREEN: begin
                if (!bus.preempt) begin
                    state_d = ST_YELLOW;
                    timer_d = c_ONE;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        if (w_grant) begin
            active_d          = w_gdir;
            last_d            = w_gdir;
            timer_d           = c_ONE;
            pending_d[w_gdir] = 1'b0;
        end
    end

    // Lights are decoded from the next state so the registered copies track state_q exactly.
    always_comb begin
        ns_d  = light_decode(state_d, active_d, DIR_NS);
        sn_d  = light_decode(state_d, active_d, DIR_SN);
        ew_d  = light_decode(state_d, active_d, DIR_EW);
        we_d  = light_decode(state_d, active_d, DIR_WE);
        ack_d = (state_d == ST_PREEMPT_GREEN);
    end

    assign bus.NS_light    = ns_q;
    assign bus.SN_light    = sn_q;
    assign bus.EW_light    = ew_q;
    assign bus.WE_light    = we_q;
    assign bus.active_dir  = active_q;
    assign bus.phase_state = state_q;
    assign bus.preempt_ack = ack_q;

endmodule
`default_nettype wire

// File: doc/traffic_phase_arbiter.md
Name: traffic_phase_arbiter

Overview:
- Schedules green time among the four approaches NS, SN, EW and WE of the adaptive intersection.
- Inputs: per-approach demand sensors (S1 class) and per-approach queue/extension sensors (S5 class), plus an emergency preemption request.
- Arbitration: round-robin with min/max green, fixed yellow and all-red clearance, and preemption override.
- Drives the four 2-bit light outputs consumed by the intersection I/O.

Parameters:
- MIN_GREEN, 4, minimum green duration in cycles (normal service).
- MAX_GREEN, 12, green duration after which extension is ignored if another approach is waiting.
- YELLOW_T, 3, yellow duration in cycles.
- ALL_RED_T, 2, all-red clearance duration in cycles.
- TW, 4, timer width; must hold MAX_GREEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- req  in  4  demand sensors; bit0 NS, bit1 SN, bit2 EW, bit3 WE.
- ext  in  4  extension (queue present) sensors, same bit order.
- preempt  in  1  emergency preemption request, level.
- preempt_dir  in  2  approach to serve during preemption (0 NS, 1 SN, 2 EW, 3 WE).
- NS_light, SN_light, EW_light, WE_light  out  2 each  00 RED, 01 YELLOW, 10 GREEN.
- active_dir  out  2  approach currently green, yellow, or last served.
- phase_state  out  3  current FSM state code.
- preempt_ack  out  1  high while in PREEMPT_GREEN.

Behaviour:
- Reset, sampled at posedge with rst low:
  - state IDLE, all lights 00, active_dir 0, phase_state IDLE.
  - preempt_ack 0, timer 0, pending 0.
  - last_dir 3, so the first round-robin search starts at NS.
- Outputs are registered Moore decode of state/active_dir and change only on clk edges.
- Demand latching: pending[i] is set whenever req[i] is sampled high. Effective demand is eff = pending | req.
- pending[i] clears on entry to GREEN or PREEMPT_GREEN for approach i. A req held high re-latches in the next cycle.
- Selection: first set bit of eff, searched from (last_dir+1) mod 4 upward with wrap. Chosen approach becomes active_dir and last_dir.
- State codes: IDLE=0, GREEN=1, YELLOW=2, ALL_RED=3, PREEMPT_GREEN=4.
- IDLE (all red):
  - preempt high → PREEMPT_GREEN next edge.
  - else any eff bit → GREEN next edge.
  - else stay.
- GREEN: timer counts from 1 and saturates at MAX_GREEN. Leave for YELLOW at the edge where any of these holds:
  - timer >= MIN_GREEN and ext[active]==0;
  - timer == MAX_GREEN and eff has another bit set;
  - preempt high and preempt_dir != active_dir (immediate; min green is ignored).
- GREEN rest: at MAX_GREEN with ext[active] high and no other demand, green holds indefinitely.
- GREEN with preempt high and preempt_dir == active_dir → PREEMPT_GREEN, no clearance.
- YELLOW lasts exactly YELLOW_T cycles, then ALL_RED.
- ALL_RED lasts exactly ALL_RED_T cycles, then:
  - PREEMPT_GREEN if a preempt is latched;
  - else GREEN for the next selected approach if eff != 0;
  - else IDLE.
- Preemption latch: preempt_dir is captured on the first cycle preempt is sampled high. Later changes are ignored until preempt deasserts.
- A preempt seen during YELLOW or ALL_RED does not shorten clearance.
- PREEMPT_GREEN: only the latched approach is green. It holds while preempt is high; preempt_ack=1. On deassert → YELLOW → ALL_RED → normal selection. last_dir is set to the preempt approach.
- Exactly one approach is non-red at any time; never green to green without YELLOW + ALL_RED, except in the same-approach preempt case.
- Reset mid-operation wins over every transition: next cycle is all red, IDLE, with the latches cleared.

Decomposition:
- Package traffic_pkg holds:
  - light encodings LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN;
  - state codes;
  - direction indices DIR_NS, DIR_SN, DIR_EW, DIR_WE.
- Sub-module rr_select: combinational 4-way round-robin picker. Inputs eff[3:0], last_dir; outputs sel_dir, any.

Test Plan:
- Reset: hold rst=0 for 2 edges during an active NS green → all lights 00, phase_state 0, preempt_ack 0 on the following cycle.
- Single pulse req[0] for 1 cycle, ext=0 → NS_light=10 for exactly 4 cycles, 01 for 3, all 00 for 2, then IDLE.
- Max green: req[0] pulse, ext[0] held 1, req[2] pulse at cycle 3 → NS green 12 cycles, yellow 3, all-red 2, then EW green.
- Round-robin: req=1111 for 1 cycle from IDLE, ext=0 → green order NS, SN, EW, WE, each 4 cycles separated by 3+2 clearance, then IDLE.
- Rest in green: req[1] pulse, ext[1] held 1 → SN green persists at cycle 20. Pulse req[3] → SN_light=01 on the next edge; WE green after 5 clearance cycles.
- Preemption: during EW green at timer=2, assert preempt with dir=3 → EW yellow next edge (3 cycles), all red 2, then WE green with preempt_ack=1 while held. Deassert → yellow 3, all red 2, then service of remaining pending.
